ahb_dma_arbiter: RTL and testbench

- Two-master AHB arbiter feeding the DMAC's Bus_Grant; sits directly upstream of Dmac_Top on the system bus.
- Arbitrates between the CPU master (M0) and the DMAC master (M1) and drives the shared slave-side address/control and write-data buses.
- Ownership changes only at burst boundaries.
- A tenure limit stops the DMAC from starving the CPU.

---
 rtl/dmac_ahb_pkg.sv | 26 ++
 rtl/ahb_burst_tracker.sv | 47 ++++
 rtl/ahb_dma_arbiter.sv | 107 ++++++++++
 tb/tb_ahb_dma_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmac_ahb_pkg.sv
// Shared types for the two-master AHB arbiter in front of the DMAC.
package dmac_ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

  // Arbiter state kept as plain constants so older tools see a simple vector.
  typedef logic arb_state_t;
  localparam arb_state_t S_CPU = 1'b0;
  localparam arb_state_t S_DMA = 1'b1;

  // A burst length field of zero still moves one beat.
  function automatic logic [4:0] burst_beats(input logic [3:0] len);
    return (len == 4'd0) ? 5'd1 : {1'b0, len};
  endfunction

endpackage

// File: rtl/ahb_burst_tracker.sv
// Beat counter for the master currently owning the address phase; flags the
// cycle in which that master's burst boundary is reached.
module ahb_burst_tracker
  import dmac_ahb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] trans,
  input  logic [3:0] len,
  input  logic       hready,
  output logic       burst_end
);

  logic [3:0] count_q;
  logic [3:0] count_d;
  htrans_t    trans_e;
  logic [4:0] beats;
  logic       nonseq_acc;
  logic       seq_acc;

  // Count remaining beats and decide whether this cycle closes the burst.
  always_comb begin
    trans_e    = htrans_t'(trans);
    beats      = burst_beats(len);
    nonseq_acc = hready && (trans_e == NONSEQ);
    seq_acc    = hready && (trans_e == SEQ);
    count_d    = count_q;
    if (nonseq_acc) begin
      count_d = 4'(beats - 5'd1);
    end else if (seq_acc && (count_q != 4'd0)) begin
      count_d = count_q - 4'd1;
    end
    burst_end = hready &&
                (((count_q == 4'd0) && !(nonseq_acc && (beats > 5'd1))) ||
                 ((count_q == 4'd1) && seq_acc));
  end

  // Beat counter register; a reset mid-burst simply discards the burst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ahb_dma_arbiter.sv
// Two-master AHB arbiter (CPU = M0, DMAC = M1). Ownership moves only on burst
// boundaries, and a tenure limit forces the DMAC to yield to a waiting CPU.
module ahb_dma_arbiter
  import dmac_ahb_pkg::*;
#(
  parameter int MAX_TENURE = 16,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [1:0]        cpu_trans,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_write,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [3:0]        cpu_burst,
  input  logic              Bus_Req,
  input  logic [1:0]        MTrans,
  input  logic [ADDR_W-1:0] MAddress,
  input  logic              MWrite,
  input  logic [DATA_W-1:0] MWData,
  input  logic [3:0]        MBurst_Size,
  input  logic              HReady,
  output logic              cpu_grant,
  output logic              Bus_Grant,
  output logic [1:0]        s_trans,
  output logic [ADDR_W-1:0] s_addr,
  output logic              s_write,
  output logic [DATA_W-1:0] s_wdata,
  output logic              addr_owner,
  output logic              data_owner
);

  localparam int              TEN_W   = $clog2(MAX_TENURE + 1);
  localparam logic [TEN_W-1:0] TEN_MAX = TEN_W'(MAX_TENURE);

  arb_state_t       state_q;
  arb_state_t       state_d;
  logic [TEN_W-1:0] tenure_q;
  logic [TEN_W-1:0] tenure_d;
  logic [TEN_W-1:0] tenure_inc;
  owner_t           data_owner_q;
  owner_t           data_owner_d;
  logic [3:0]       trk_len;
  logic             burst_end;
  logic             dma_beat;

  // Grants come straight from the registered state, so exactly one is high.
  assign cpu_grant  = (state_q == S_CPU);
  assign Bus_Grant  = (state_q == S_DMA);
  assign addr_owner = Bus_Grant;
  assign data_owner = (data_owner_q == OWN_DMA);

  // Address/control follow the address-phase owner; write data follows the
  // data-phase owner, which trails by one accepted HReady cycle.
  always_comb begin
    s_trans = addr_owner ? MTrans      : cpu_trans;
    s_addr  = addr_owner ? MAddress    : cpu_addr;
    s_write = addr_owner ? MWrite      : cpu_write;
    trk_len = addr_owner ? MBurst_Size : cpu_burst;
    s_wdata = data_owner ? MWData      : cpu_wdata;
  end

  ahb_burst_tracker u_tracker (
    .clk       (clk),
    .rst       (rst),
    .trans     (s_trans),
    .len       (trk_len),
    .hready    (HReady),
    .burst_end (burst_end)
  );

  // Ownership decision; the tenure test includes the beat accepted this
  // cycle so the DMAC yields after exactly MAX_TENURE beats.
  always_comb begin
    dma_beat     = (state_q == S_DMA) && HReady && MTrans[1];
    tenure_inc   = (dma_beat && (tenure_q < TEN_MAX)) ? tenure_q + 1'b1 : tenure_q;
    state_d      = state_q;
    tenure_d     = tenure_inc;
    data_owner_d = HReady ? (addr_owner ? OWN_DMA : OWN_CPU) : data_owner_q;
    if (burst_end) begin
      if (state_q == S_CPU) begin
        if (Bus_Req) begin
          state_d  = S_DMA;
          tenure_d = '0;
        end
      end else if (!Bus_Req || (cpu_req && (tenure_inc >= TEN_MAX))) begin
        state_d = S_CPU;
      end
    end
  end

  // State, tenure and data-phase owner registers; CPU is parked on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_CPU;
      tenure_q     <= '0;
      data_owner_q <= OWN_CPU;
    end else begin
      state_q      <= state_d;
      tenure_q     <= tenure_d;
      data_owner_q <= data_owner_d;
    end
  end

endmodule

// File: tb/tb_ahb_dma_arbiter.sv
// Scoreboard bench for ahb_dma_arbiter: a behavioural bus model predicts the
// outputs of every cycle, a monitor compares them, and directed phases check
// the tenure limit, write-data handover and asynchronous reset.
module tb_ahb_dma_arbiter;

  localparam int MAX_TENURE = 16;
  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic [1:0]  cpu_trans;
  logic [31:0] cpu_addr;
  logic        cpu_write;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_burst;
  logic        Bus_Req;
  logic [1:0]  MTrans;
  logic [31:0] MAddress;
  logic        MWrite;
  logic [31:0] MWData;
  logic [3:0]  MBurst_Size;
  logic        HReady;
  logic        cpu_grant;
  logic        Bus_Grant;
  logic [1:0]  s_trans;
  logic [31:0] s_addr;
  logic        s_write;
  logic [31:0] s_wdata;
  logic        addr_owner;
  logic        data_owner;

  ahb_dma_arbiter #(.MAX_TENURE(MAX_TENURE), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_trans(cpu_trans),
    .cpu_addr(cpu_addr), .cpu_write(cpu_write), .cpu_wdata(cpu_wdata),
    .cpu_burst(cpu_burst), .Bus_Req(Bus_Req), .MTrans(MTrans),
    .MAddress(MAddress), .MWrite(MWrite), .MWData(MWData),
    .MBurst_Size(MBurst_Size), .HReady(HReady), .cpu_grant(cpu_grant),
    .Bus_Grant(Bus_Grant), .s_trans(s_trans), .s_addr(s_addr),
    .s_write(s_write), .s_wdata(s_wdata), .addr_owner(addr_owner),
    .data_owner(data_owner)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        cpuGrant;
    logic        busGrant;
    logic        addrOwner;
    logic        dataOwner;
    logic        sWrite;
    logic [1:0]  sTrans;
    logic [31:0] sAddr;
    logic [31:0] sWdata;
  } expect_t;

  expect_t sbQueue[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model: who owns the bus, beats still owed by the open burst,
  // and how many beats the DMAC has moved since it was granted.
  int mOwner, mDataOwner, mRem, mDmaRun;

  // Stimulus masters (index 0 = CPU, 1 = DMAC) issuing well-formed bursts.
  logic [1:0]  gTrans[2];
  logic [3:0]  gLen[2];
  logic [31:0] gAddr[2];
  logic        gWrite[2];
  int          gLeft[2];

  int pReady, pBusReq, pCpuReq, pBusy;
  int pIdle[2];
  int fixLen[2];
  bit fixData;

  int dmaBeatsSeen = 0;
  int cpuBeatsSeen = 0;

  task automatic checkField(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkOutput(input expect_t e);
    checkField("cpu_grant",  32'(cpu_grant),  32'(e.cpuGrant));
    checkField("Bus_Grant",  32'(Bus_Grant),  32'(e.busGrant));
    checkField("addr_owner", 32'(addr_owner), 32'(e.addrOwner));
    checkField("data_owner", 32'(data_owner), 32'(e.dataOwner));
    checkField("s_write",    32'(s_write),    32'(e.sWrite));
    checkField("s_trans",    32'(s_trans),    32'(e.sTrans));
    checkField("s_addr",     s_addr,          e.sAddr);
    checkField("s_wdata",    s_wdata,         e.sWdata);
  endtask

  task automatic modelReset();
    mOwner = 0; mDataOwner = 0; mRem = 0; mDmaRun = 0;
  endtask

  // One clock edge of the bus as the rules describe it, using the inputs
  // that were stable across that edge.
  task automatic modelStep();
    logic [1:0] t;
    int len;
    bit boundary;
    int prevOwner;
    if (!HReady) return;
    t   = mOwner ? MTrans : cpu_trans;
    len = mOwner ? int'(MBurst_Size) : int'(cpu_burst);
    if (len == 0) len = 1;
    case (t)
      T_NONSEQ: begin
        mRem = len - 1;
        boundary = (len == 1);
      end
      T_SEQ: begin
        if (mRem > 0) begin
          mRem--;
          boundary = (mRem == 0);
        end else boundary = 1'b1;
      end
      default: boundary = (mRem == 0);
    endcase
    if (mOwner == 1 && t[1]) mDmaRun++;
    prevOwner = mOwner;
    if (boundary) begin
      if (mOwner == 0 && Bus_Req) begin
        mOwner = 1;
        mDmaRun = 0;
      end else if (mOwner == 1 && (!Bus_Req || (cpu_req && mDmaRun >= MAX_TENURE))) begin
        mOwner = 0;
      end
    end
    mDataOwner = prevOwner;
  endtask

  task automatic newTransfer(input int m);
    int len;
    if (fixLen[m] != 0) len = fixLen[m];
    else begin
      case ($urandom_range(5))
        0: len = 0;
        1: len = 1;
        2, 3: len = 4;
        4: len = 8;
        default: len = int'($urandom_range(15, 2));
      endcase
    end
    gLen[m]   = 4'(len);
    gAddr[m]  = $urandom & 32'hFFFF_FFFC;
    gWrite[m] = fixData ? 1'b1 : 1'($urandom_range(1));
    if (int'($urandom_range(99)) < pIdle[m]) begin
      gTrans[m] = T_IDLE;
      gLeft[m]  = 0;
    end else begin
      gTrans[m] = T_NONSEQ;
      gLeft[m]  = (len == 0) ? 0 : len - 1;
    end
  endtask

  task automatic advance(input int m);
    case (gTrans[m])
      T_NONSEQ, T_SEQ: begin
        if (gLeft[m] > 0) begin
          if (int'($urandom_range(99)) < pBusy) gTrans[m] = T_BUSY;
          else begin
            gTrans[m] = T_SEQ;
            gLeft[m]--;
            gAddr[m] += 32'd4;
          end
        end else newTransfer(m);
      end
      T_BUSY: begin
        gTrans[m] = T_SEQ;
        gLeft[m]--;
        gAddr[m] += 32'd4;
      end
      default: newTransfer(m);
    endcase
  endtask

  task automatic pushExpected();
    expect_t e;
    e.cpuGrant  = (mOwner == 0);
    e.busGrant  = (mOwner == 1);
    e.addrOwner = (mOwner == 1);
    e.dataOwner = (mDataOwner == 1);
    e.sTrans    = (mOwner == 1) ? MTrans   : cpu_trans;
    e.sAddr     = (mOwner == 1) ? MAddress : cpu_addr;
    e.sWrite    = (mOwner == 1) ? MWrite   : cpu_write;
    e.sWdata    = (mDataOwner == 1) ? MWData : cpu_wdata;
    sbQueue.push_back(e);
  endtask

  // Advance model and masters past one edge, drive the next cycle's inputs,
  // and queue the outputs the DUT must show during that cycle.
  task automatic applyStimulus();
    int oldOwner;
    bit hr;
    @(posedge clk);
    #1;
    if (!rst) begin
      modelReset();
      newTransfer(0);
      newTransfer(1);
    end else begin
      oldOwner = mOwner;
      hr = HReady;
      modelStep();
      for (int m = 0; m < 2; m++) begin
        if (m == oldOwner) begin
          if (hr) advance(m);
        end else newTransfer(m);
      end
    end
    HReady      = (int'($urandom_range(99)) < pReady);
    Bus_Req     = (int'($urandom_range(99)) < pBusReq);
    cpu_req     = (int'($urandom_range(99)) < pCpuReq);
    cpu_trans   = gTrans[0];
    cpu_burst   = gLen[0];
    cpu_addr    = gAddr[0];
    cpu_write   = gWrite[0];
    MTrans      = gTrans[1];
    MBurst_Size = gLen[1];
    MAddress    = gAddr[1];
    MWrite      = gWrite[1];
    cpu_wdata   = fixData ? 32'hAABBCCDD : $urandom;
    MWData      = fixData ? 32'h11223344 : $urandom;
    pushExpected();
  endtask

  // Monitor: every cycle the DUT presents a new output set at the falling edge.
  always @(negedge clk) begin : monitor
    expect_t e;
    if (sbQueue.size() > 0) begin
      e = sbQueue.pop_front();
      checkOutput(e);
    end
  end

  // Beats each master actually moves during its current grant on the DUT.
  always @(negedge clk) begin
    if (!Bus_Grant) dmaBeatsSeen = 0;
    else if (HReady && MTrans[1]) dmaBeatsSeen++;
    if (!cpu_grant) cpuBeatsSeen = 0;
    else if (HReady && cpu_trans[1]) cpuBeatsSeen++;
  end

  initial begin
    rst = 1'b0;
    cpu_req = 0; cpu_trans = T_IDLE; cpu_addr = '0; cpu_write = 0; cpu_wdata = '0; cpu_burst = '0;
    Bus_Req = 0; MTrans = T_IDLE; MAddress = '0; MWrite = 0; MWData = '0; MBurst_Size = '0;
    HReady = 1'b1;
    pReady = 80; pBusReq = 50; pCpuReq = 50; pBusy = 10;
    pIdle[0] = 30; pIdle[1] = 30; fixLen[0] = 0; fixLen[1] = 0; fixData = 0;
    modelReset();

    // Reset held with random inputs: parked CPU expected.
    repeat (3) applyStimulus();
    @(negedge clk); #1 rst = 1'b1;

    // Idle CPU, DMAC requesting: DMAC takes the bus at the first boundary.
    pIdle[0] = 100; pCpuReq = 0; pBusReq = 100; pReady = 80;
    repeat (20) applyStimulus();

    // DMAC drops its request and the bus returns to the CPU.
    pBusReq = 0;
    for (int i = 0; i < 64 && !cpu_grant; i++) begin applyStimulus(); #1; end
    checkField("release_to_cpu", 32'(cpu_grant), 32'd1);

    // Tenure limit with back-to-back 4-beat DMAC write bursts and a waiting CPU.
    pReady = 100; pBusReq = 100; pCpuReq = 100; pBusy = 0;
    pIdle[0] = 0; pIdle[1] = 0; fixLen[0] = 4; fixLen[1] = 4; fixData = 1;
    for (int i = 0; i < 32 && !Bus_Grant; i++) begin applyStimulus(); #1; end
    checkField("dma_granted", 32'(Bus_Grant), 32'd1);
    for (int i = 0; i < 64 && !cpu_grant; i++) begin applyStimulus(); #1; end
    checkField("forced_yield", 32'(cpu_grant), 32'd1);
    checkField("dma_tenure_beats", 32'(dmaBeatsSeen), 32'(MAX_TENURE));
    checkField("last_dma_data_owner", 32'(data_owner), 32'd1);
    checkField("last_dma_wdata", s_wdata, 32'h11223344);
    applyStimulus(); #1;
    checkField("cpu_data_owner", 32'(data_owner), 32'd0);
    checkField("cpu_wdata", s_wdata, 32'hAABBCCDD);
    for (int i = 0; i < 32 && !Bus_Grant; i++) begin applyStimulus(); #1; end
    checkField("dma_regranted", 32'(Bus_Grant), 32'd1);
    checkField("cpu_burst_beats", 32'(cpuBeatsSeen), 32'd4);

    // Asynchronous reset while the DMAC owns the bus.
    pReady = 70; pCpuReq = 0; fixLen[0] = 0; fixLen[1] = 0; fixData = 0;
    pIdle[0] = 50; pIdle[1] = 10; pBusy = 10;
    for (int i = 0; i < 32 && mOwner != 1; i++) applyStimulus();
    #1;
    checkField("pre_reset_dma_owner", 32'(Bus_Grant), 32'd1);
    @(negedge clk); #1 rst = 1'b0;
    #1;
    checkField("async_rst_cpu_grant", 32'(cpu_grant), 32'd1);
    checkField("async_rst_bus_grant", 32'(Bus_Grant), 32'd0);
    checkField("async_rst_addr_owner", 32'(addr_owner), 32'd0);
    checkField("async_rst_data_owner", 32'(data_owner), 32'd0);
    repeat (3) applyStimulus();
    @(negedge clk); #1 rst = 1'b1;

    // Broad random traffic, then heavy contention to exercise the limit.
    pReady = 75; pBusReq = 60; pCpuReq = 50; pBusy = 15; pIdle[0] = 30; pIdle[1] = 20;
    repeat (2500) applyStimulus();
    pReady = 85; pBusReq = 95; pCpuReq = 90; pIdle[0] = 10; pIdle[1] = 5;
    repeat (1500) applyStimulus();

    @(negedge clk); #1;
    checkField("scoreboard_drained", 32'(sbQueue.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
